stats_report_tx: RTL
====================

Name: stats_report_tx

Overview:
UART transmitter that serializes a snapshot of the pet's six 4-bit stats and the 8-bit status register into a fixed 6-byte binary frame. It sits beside the command receiver in the top level and drives the TX pin. It is triggered by the once-per-second tick or by a host request. A host-side decoder reconstructs the pet state from the frame.

Parameters:
CLKS_PER_BIT, 1042, clock cycles per UART bit (10 MHz / 9600 baud); legal range >= 2.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
send  input  1  request one frame; level-sampled each cycle
hunger  input  4  stat snapshot source
happiness  input  4  stat snapshot source
health  input  4  stat snapshot source
hygiene  input  4  stat snapshot source
energy  input  4  stat snapshot source
social  input  4  stat snapshot source
status  input  8  status register snapshot source
uart_tx  output  1  serial line; idle high
busy  output  1  high while a frame is in flight
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: uart_tx=1, busy=0, done=0, FSM=IDLE, all counters and the snapshot are 0.
- Frame format, in byte order:
  - B0 = SYNC_BYTE
  - B1 = {hunger,happiness}
  - B2 = {health,hygiene}
  - B3 = {energy,social}
  - B4 = status
  - B5 = B1^B2^B3^B4 (8-bit XOR checksum)
- Byte format: 8N1. Start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Bytes are sent back-to-back with no idle gap. Frame length is exactly 60*CLKS_PER_BIT cycles.
- Accept: on the rising edge where send=1 and busy=0:
  - all inputs are captured into snapshot registers and the checksum is computed from the snapshot;
  - busy goes 1 and uart_tx goes 0 (start of B0) at that same edge.
  - Input changes after the accept edge do not affect the frame.
- send while busy=1 is ignored and not queued. send held high continuously yields back-to-back frames separated by exactly one idle cycle (uart_tx=1).
- FSM states:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA (8 bits, bit index 0..7) -> STOP.
  - STOP -> START with byte index +1 if byte index < 5.
  - STOP -> IDLE if byte index == 5; that edge sets busy=0, uart_tx stays 1, done=1 for one cycle.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide; it counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index is 3 bits; byte index is 3 bits, range 0..5 (never reaches 6).
- uart_tx is registered (glitch-free). No combinational path exists from inputs to uart_tx.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously), busy=0 and the frame is abandoned. The first send after reset release starts a fresh frame at B0.
- done and an accept cannot coincide, because busy is still 1 on the done edge.

Decomposition:
- Shared package tama_pkg: SYNC_BYTE default, FRAME_BYTES=6, BITS_PER_BYTE=8, the FSM state enum (IDLE, START, DATA, STOP), and a checksum function. The same package is reused by the receiver and by the host model.
- One sub-module, uart_byte_tx: single-byte 8N1 serializer with a start/data_in/ready handshake and the baud counter.
- stats_report_tx keeps the snapshot, the byte-index sequencing, busy and done.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
1. Reset, then 100 idle cycles -> uart_tx=1, busy=0, done never asserts.
2. Snapshot inputs hunger=3, happiness=C, health=F, hygiene=1, energy=8, social=0, status=42; send pulse for 1 cycle -> line decodes to A5 3C F1 80 42 0F. busy is high for exactly 240 cycles; done pulses once at cycle 240.
3. Change every input to F and pulse send again, both in cycle 10 of the frame from scenario 2 -> frame content is unchanged and no second frame follows.
4. Hold send high for 600 cycles -> consecutive frames, each 240 cycles long, separated by a single idle-high cycle. Every frame begins with A5 and carries a valid checksum.
5. Assert rst_n low during B2 data bits -> uart_tx=1 and busy=0 in the same cycle. After release, a send produces a complete fresh frame starting with A5.
6. Bit-timing check on the B0 start bit and each data bit -> every level holds exactly 4 cycles, LSB first (A5 sends bits 1,0,1,0,0,1,0,1).

Source files
------------

// File: rtl/tama_pkg.sv
// tama_pkg: constants, transmitter state type and frame checksum for the pet UART link.
package tama_pkg;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int FRAME_BYTES = 6;
  localparam int BITS_PER_BYTE = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic logic [7:0] checksum(input logic [3:0][7:0] payload);
    return payload[0] ^ payload[1] ^ payload[2] ^ payload[3];
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 single-byte serializer; ready is high in the last stop-bit cycle so bytes chain without a gap.
module uart_byte_tx
  import tama_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       ready
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_t state;
  logic [CW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic bit_end;
  always_comb begin
    bit_end = baud == CW'(CLKS_PER_BIT - 1);
    ready = state == IDLE || (state == STOP && bit_end);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else if (ready && start) begin
      state <= START;
      baud <= '0;
      bit_idx <= '0;
      shift <= data_in;
      tx <= 1'b0;
    end else if (state != IDLE) begin
      baud <= bit_end ? '0 : baud + 1'b1;
      if (bit_end)
        case (state)
          START: begin
            state <= DATA;
            tx <= shift[0];
            shift <= shift >> 1;
          end
          DATA: begin
            state <= bit_idx == 3'(BITS_PER_BYTE - 1) ? STOP : DATA;
            tx <= bit_idx == 3'(BITS_PER_BYTE - 1) ? 1'b1 : shift[0];
            shift <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
          default: begin
            state <= IDLE;
            tx <= 1'b1;
          end
        endcase
    end
endmodule

// File: rtl/stats_report_tx.sv
// stats_report_tx: snapshots the pet stats and streams them as a 6-byte sync/payload/checksum UART frame.
module stats_report_tx
  import tama_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1042,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] energy,
  input  logic [3:0] social,
  input  logic [7:0] status,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);
  logic [3:0][7:0] snap;
  logic [2:0] byte_idx;
  logic accept, ready, last, start;
  logic [7:0] data_in;
  // byte_idx names the byte currently on the line, so the byte queued next is payload byte_idx
  always_comb begin
    accept = send && !busy;
    last = byte_idx == 3'(FRAME_BYTES - 1);
    start = accept || (busy && ready && !last);
    data_in = accept ? SYNC_BYTE :
              byte_idx == 3'(FRAME_BYTES - 2) ? checksum(snap) : snap[byte_idx[1:0]];
  end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data_in(data_in),
    .tx(uart_tx),
    .ready(ready)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snap <= '0;
      byte_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= busy && ready && last;
      if (accept) begin
        snap <= {status, energy, social, health, hygiene, hunger, happiness};
        byte_idx <= '0;
        busy <= 1'b1;
      end else if (busy && ready) begin
        busy <= !last;
        byte_idx <= last ? byte_idx : byte_idx + 1'b1;
      end
    end
endmodule
